// File: rtl/mux_tree_pipe_if.sv
// rtl/mux_tree_pipe_if.sv - handshake bundle for mux_tree_pipe (out_err only with MUX_TREE_PIPE_ERR_EN)
interface mux_tree_pipe_if #(
    parameter int WIDTH    = 4,
    parameter int N_INPUTS = 4,
    parameter int SEL_W    = $clog2(N_INPUTS)
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N_INPUTS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
`ifdef MUX_TREE_PIPE_ERR_EN
    logic                      out_err;
`endif

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
`ifdef MUX_TREE_PIPE_ERR_EN
        , input out_err
`endif
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
`ifdef MUX_TREE_PIPE_ERR_EN
        , output out_err
`endif
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 binary mux tree, one register level per sel bit (MUX_TREE_PIPE_ERR_EN adds out_err)
module mux_tree_pipe #(
    parameter int WIDTH    = 4,
    parameter int N_INPUTS = 4,
    parameter int SEL_W    = $clog2(N_INPUTS),
    parameter int LEVELS   = $clog2(N_INPUTS)
) (
    input logic            clk,
    input logic            rst_n,
    mux_tree_pipe_if.slave bus
);

    logic             advance;

    // Each level keeps N_INPUTS slots; slots past the level's real element count stay zero.
    logic [WIDTH-1:0] dat_q [1:LEVELS][N_INPUTS];
    logic [WIDTH-1:0] dat_d [1:LEVELS][N_INPUTS];
    logic [WIDTH-1:0] lvl   [0:LEVELS][N_INPUTS];
    logic [SEL_W-1:0] sel_q [1:LEVELS];
    logic [SEL_W-1:0] sel_a [0:LEVELS];
    logic             vld_q [1:LEVELS];
`ifdef MUX_TREE_PIPE_ERR_EN
    logic             err_q [1:LEVELS];
    logic             err_in;

    assign err_in = {1'b0, bus.in_sel} >= N_INPUTS[SEL_W:0];
`endif

    assign advance      = !vld_q[LEVELS] || bus.out_ready;
    assign bus.in_ready = advance;

    always_comb begin
        for (int i = 0; i < N_INPUTS; i++) begin
            lvl[0][i] = bus.in_data[i*WIDTH +: WIDTH];
        end
        sel_a[0] = bus.in_sel;
        for (int k = 1; k <= LEVELS; k++) begin
            sel_a[k] = sel_q[k];
            for (int j = 0; j < N_INPUTS; j++) begin
                lvl[k][j] = dat_q[k][j];
            end
        end
        // An unpaired trailing element (or a missing leaf) reads as zero when its
        // sel bit is 1, which also makes out-of-range selects come out as zero.
        for (int k = 1; k <= LEVELS; k++) begin
            for (int j = 0; j < N_INPUTS; j++) begin
                dat_d[k][j] = '0;
                if (2*j < N_INPUTS) begin
                    if (sel_a[k-1][k-1]) begin
                        if (2*j + 1 < N_INPUTS) begin
                            dat_d[k][j] = lvl[k-1][2*j+1];
                        end
                    end else begin
                        dat_d[k][j] = lvl[k-1][2*j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LEVELS; k++) begin
                vld_q[k] <= 1'b0;
                sel_q[k] <= '0;
`ifdef MUX_TREE_PIPE_ERR_EN
                err_q[k] <= 1'b0;
`endif
                for (int j = 0; j < N_INPUTS; j++) begin
                    dat_q[k][j] <= '0;
                end
            end
        end else if (advance) begin
            vld_q[1] <= bus.in_valid;
            sel_q[1] <= bus.in_sel;
`ifdef MUX_TREE_PIPE_ERR_EN
            err_q[1] <= err_in;
`endif
            for (int k = 2; k <= LEVELS; k++) begin
                vld_q[k] <= vld_q[k-1];
                sel_q[k] <= sel_q[k-1];
`ifdef MUX_TREE_PIPE_ERR_EN
                err_q[k] <= err_q[k-1];
`endif
            end
            for (int k = 1; k <= LEVELS; k++) begin
                for (int j = 0; j < N_INPUTS; j++) begin
                    dat_q[k][j] <= dat_d[k][j];
                end
            end
        end
    end

    assign bus.out_valid = vld_q[LEVELS];
    assign bus.out_data  = dat_q[LEVELS][0];
    assign bus.out_sel   = sel_q[LEVELS];
`ifdef MUX_TREE_PIPE_ERR_EN
    assign bus.out_err   = err_q[LEVELS];
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - randomized self-checking bench for mux_tree_pipe against a delay-line reference
module tb_mux_tree_pipe;
    localparam int WIDTH = 8;
    localparam int N     = 5;
    localparam int SEL_W = $clog2(N);
    localparam int L     = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_tree_pipe_if #(.WIDTH(WIDTH), .N_INPUTS(N), .SEL_W(SEL_W)) bus ();

    mux_tree_pipe #(.WIDTH(WIDTH), .N_INPUTS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_valid_cyc = -1;
    logic [WIDTH-1:0] first_valid_data = '0;

    logic [WIDTH-1:0] w [N];
    bit               mv [L];
    logic [WIDTH-1:0] md [L];
    logic [SEL_W-1:0] ms [L];
    bit               me [L];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick(input int s);
        return (s < N) ? w[s] : '0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < L; i++) begin
            mv[i] = 0; md[i] = '0; ms[i] = '0; me[i] = 0;
        end
    endtask

    task automatic check_out(input string ph);
        check({ph, "_out_valid"}, 32'(bus.out_valid), 32'(mv[L-1]));
        if (mv[L-1]) begin
            check({ph, "_out_data"}, 32'(bus.out_data), 32'(md[L-1]));
            check({ph, "_out_sel"}, 32'(bus.out_sel), 32'(ms[L-1]));
`ifdef MUX_TREE_PIPE_ERR_EN
            check({ph, "_out_err"}, 32'(bus.out_err), 32'(me[L-1]));
`endif
        end
    endtask

    // One clock: check outputs at negedge, drive the next beat, update the reference at posedge.
    task automatic cycle(input bit v, input int s, input bit ordy);
        bit adv;
        @(negedge clk);
        cyc++;
        check_out("run");
        if (bus.out_valid && first_valid_cyc < 0) begin
            first_valid_cyc  = cyc;
            first_valid_data = bus.out_data;
        end
        bus.in_valid  = v;
        bus.in_sel    = SEL_W'(s);
        bus.out_ready = ordy;
        for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = w[i];
        #1;
        adv = !mv[L-1] || ordy;
        check("in_ready", 32'(bus.in_ready), 32'(adv));
        @(posedge clk);
        if (adv) begin
            for (int i = L-1; i > 0; i--) begin
                mv[i] = mv[i-1]; md[i] = md[i-1]; ms[i] = ms[i-1]; me[i] = me[i-1];
            end
            mv[0] = v;
            md[0] = pick(s);
            ms[0] = SEL_W'(s);
            me[0] = (s >= N);
        end
    endtask

    task automatic randomize_words();
        for (int i = 0; i < N; i++) w[i] = WIDTH'($urandom);
    endtask

    initial begin
        int c0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++) w[i] = WIDTH'(8'h11 * (i + 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_sel", 32'(bus.out_sel), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
`ifdef MUX_TREE_PIPE_ERR_EN
        check("rst_out_err", 32'(bus.out_err), 0);
`endif
        rst_n = 1'b1;

        // Latency and top-element select: sel=4 -> 0x55 after L cycles
        c0 = cyc + 1;
        cycle(1, 4, 1);
        for (int i = 0; i < L + 2; i++) cycle(0, 0, 1);
        check("latency", 32'(first_valid_cyc - c0), 32'(L));
        check("lat_data", 32'(first_valid_data), 32'h55);

        // Out-of-range selects and every in-range select in turn
        for (int s = 0; s < 8; s++) cycle(1, s, 1);
        for (int i = 0; i < L + 1; i++) cycle(0, 0, 1);

        // Backpressure: out_ready low for 3 cycles after the first output
        for (int s = 0; s < 4; s++) cycle(1, s, (s < 3));
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < L + 4; i++) cycle(0, 0, 1);

        // Bubble pattern 1,0,1
        cycle(1, 1, 1);
        cycle(0, 2, 1);
        cycle(1, 3, 1);
        for (int i = 0; i < L + 1; i++) cycle(0, 0, 1);

        // Randomized traffic with changing words and random backpressure
        for (int i = 0; i < 3000; i++) begin
            randomize_words();
            cycle(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 9) < 7));
        end

        // Mid-stream reset with beats in flight
        randomize_words();
        cycle(1, 1, 1);
        cycle(1, 2, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_out_data", 32'(bus.out_data), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        model_clear();
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < L + 3; i++) cycle(0, 0, 1);
        cycle(1, 0, 1);
        for (int i = 0; i < L + 1; i++) cycle(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
